// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - signal bundle between the board buttons and the conditioner
// Signals:
//   btn_raw     : raw, unsynchronized, bouncing button inputs (board side drives)
//   btn_level   : debounced button level per channel (conditioner drives)
//   btn_press   : one-cycle pulse when btn_level[i] rises (conditioner drives)
//   btn_release : one-cycle pulse when btn_level[i] falls (conditioner drives)
// Modports:
//   master : board / stimulus side
//   slave  : button_conditioner side
interface button_conditioner_if #(
  parameter int NUM_BTNS = 5
);
  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel synchronizer, debounce and press/release pulse generator
// Ports:
//   clk    : system clock, all state updates on the rising edge
//   rst    : asynchronous active-low reset
//   btn_if : button_conditioner_if.slave
//            btn_raw in; btn_level, btn_press, btn_release out (all NUM_BTNS wide)
// Parameters:
//   NUM_BTNS        : number of independent button channels (must match btn_if)
//   DEBOUNCE_CYCLES : consecutive stable samples needed to accept a new level (>= 2)
module button_conditioner #(
  parameter int NUM_BTNS        = 5,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave btn_if
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

  logic [NUM_BTNS-1:0] sync1_q;
  logic [NUM_BTNS-1:0] sync2_q;
  state_e              state_q [NUM_BTNS];
  logic [CNT_W-1:0]    cnt_q   [NUM_BTNS];
  logic [NUM_BTNS-1:0] level_q;
  logic [NUM_BTNS-1:0] press_q;
  logic [NUM_BTNS-1:0] release_q;

  // cnt_q holds how many consecutive samples of the new level have been seen,
  // so entering WAIT_* loads 1 and the D-th matching sample is the one that
  // finds cnt_q == D-1 and commits the transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        state_q[i] <= IDLE_LOW;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= btn_if.btn_raw;
      sync2_q   <= sync1_q;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        case (state_q[i])
          IDLE_LOW: begin
            if (sync2_q[i]) begin
              state_q[i] <= WAIT_HIGH;
              cnt_q[i]   <= CNT_ONE;
            end
          end
          WAIT_HIGH: begin
            if (!sync2_q[i]) begin
              state_q[i] <= IDLE_LOW;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_q[i] <= IDLE_HIGH;
              level_q[i] <= 1'b1;
              press_q[i] <= 1'b1;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
          IDLE_HIGH: begin
            if (!sync2_q[i]) begin
              state_q[i] <= WAIT_LOW;
              cnt_q[i]   <= CNT_ONE;
            end
          end
          WAIT_LOW: begin
            if (sync2_q[i]) begin
              state_q[i] <= IDLE_HIGH;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_q[i]   <= IDLE_LOW;
              level_q[i]   <= 1'b0;
              release_q[i] <= 1'b1;
              cnt_q[i]     <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            state_q[i] <= IDLE_LOW;
            cnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign btn_if.btn_level   = level_q;
  assign btn_if.btn_press   = press_q;
  assign btn_if.btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner with a window-based reference model
module tb_button_conditioner;

  localparam int N = 5;
  localparam int D = 4;
  localparam int W = 3 * N;

  logic clk = 1'b0;
  logic rst = 1'b0;

  button_conditioner_if #(.NUM_BTNS(N)) bif ();

  button_conditioner #(
    .NUM_BTNS       (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_if(bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [N-1:0] raw_hist[$];
  logic [N-1:0] in_hist[$];
  logic [N-1:0] m_level = '0;
  int           hold [N];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: the FSM at edge k sees the raw value captured two edges earlier.
  // A channel flips its level once the last D observed samples all differ
  // from the current level.
  task automatic model_step();
    logic [N-1:0] fsm_in;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
    bit           all_diff;
    raw_hist.push_back(bif.btn_raw);
    fsm_in = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size()-3] : '0;
    in_hist.push_back(fsm_in);
    pr = '0;
    rl = '0;
    for (int c = 0; c < N; c++) begin
      if (in_hist.size() >= D) begin
        all_diff = 1'b1;
        for (int k = 1; k <= D; k++)
          if (in_hist[in_hist.size()-k][c] == m_level[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[c] = ~m_level[c];
          if (m_level[c]) pr[c] = 1'b1;
          else            rl[c] = 1'b1;
        end
      end
    end
    while (raw_hist.size() > 8) void'(raw_hist.pop_front());
    while (in_hist.size() > 8)  void'(in_hist.pop_front());
    exp_q.push_back({rl, pr, m_level});
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        raw_hist.delete();
        in_hist.delete();
        m_level = '0;
      end else if (clk) begin
        model_step();
      end
    end
  end

  // Monitor: one expected entry per clock while out of reset; zeros while in reset.
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      got = {bif.btn_release, bif.btn_press, bif.btn_level};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (rst) check("scoreboard", 32'(got), 32'(e));
        else     check("scoreboard_in_reset", 32'(got), 32'(0));
      end else if (!rst) begin
        check("reset_outputs", 32'(got), 32'(0));
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got=%h expected=<queued entry> at t=%0t", got, $time);
      end
    end
  end

  initial begin
    bif.btn_raw = '0;
    for (int c = 0; c < N; c++) hold[c] = 0;
    #23 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Clean press on channel 0
    bif.btn_raw[0] = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 check("press_e4_level", 32'(bif.btn_level), 32'(0));
    @(posedge clk);
    #1 check("press_e5_level", 32'(bif.btn_level), 32'(5'b00001));
    check("press_e5_pulse", 32'(bif.btn_press), 32'(5'b00001));
    @(posedge clk);
    #1 check("press_e6_pulse", 32'(bif.btn_press), 32'(0));
    check("press_e6_level", 32'(bif.btn_level), 32'(5'b00001));

    // Glitch on channel 1: 3 cycles high
    @(negedge clk);
    bif.btn_raw[1] = 1'b1;
    repeat (3) @(negedge clk);
    bif.btn_raw[1] = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_level", 32'(bif.btn_level[1]), 32'(0));

    // Bounce on channel 2, then hold high
    for (int k = 0; k < 12; k++) begin
      bif.btn_raw[2] = ((k / 2) % 2 == 0);
      @(negedge clk);
    end
    bif.btn_raw[2] = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 check("bounce_e4_level", 32'(bif.btn_level[2]), 32'(0));
    @(posedge clk);
    #1 check("bounce_e5_level", 32'(bif.btn_level[2]), 32'(1));
    check("bounce_e5_pulse", 32'(bif.btn_press[2]), 32'(1));

    // Release on channel 0
    @(negedge clk);
    bif.btn_raw[0] = 1'b0;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 check("release_e4_level", 32'(bif.btn_level[0]), 32'(1));
    @(posedge clk);
    #1 check("release_e5_level", 32'(bif.btn_level[0]), 32'(0));
    check("release_e5_pulse", 32'(bif.btn_release[0]), 32'(1));
    check("release_e5_nopress", 32'(bif.btn_press[0]), 32'(0));

    // Simultaneous rise on channels 3 and 4, channel 4 glitches low at edge 2
    @(negedge clk);
    bif.btn_raw[4:3] = 2'b11;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bif.btn_raw[4] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bif.btn_raw[4] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check("simul_e4_level", 32'(bif.btn_level[4:3]), 32'(2'b00));
    @(posedge clk);
    #1 check("simul_e5_level", 32'(bif.btn_level[4:3]), 32'(2'b01));
    check("simul_e5_press", 32'(bif.btn_press[4:3]), 32'(2'b01));
    @(posedge clk);
    @(posedge clk);
    #1 check("simul_e7_level", 32'(bif.btn_level[4:3]), 32'(2'b01));
    @(posedge clk);
    #1 check("simul_e8_level", 32'(bif.btn_level[4:3]), 32'(2'b11));
    check("simul_e8_press", 32'(bif.btn_press[4:3]), 32'(2'b10));

    // Asynchronous reset mid-qualification on channel 0
    @(negedge clk);
    bif.btn_raw[0] = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset_outputs",
             32'({bif.btn_release, bif.btn_press, bif.btn_level}), 32'(0));
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 check("post_reset_e4_level", 32'(bif.btn_level[0]), 32'(0));
    @(posedge clk);
    #1 check("post_reset_e5_level", 32'(bif.btn_level[0]), 32'(1));
    check("post_reset_e5_press", 32'(bif.btn_press[0]), 32'(1));
    @(posedge clk);
    #1 check("post_reset_e6_press", 32'(bif.btn_press[0]), 32'(0));

    // Randomized holds of 1..7 cycles per channel, one async reset midway
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          bif.btn_raw[c] = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 7));
        end else begin
          hold[c] = hold[c] - 1;
        end
      end
      if (cyc == 400) begin
        #3 rst = 1'b0;
        #10 rst = 1'b1;
      end
    end

    @(negedge clk);
    bif.btn_raw = '0;
    repeat (12) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw push-button inputs from the board before they reach the OTTER_Wrapper `buttons` port.
- Per channel it does three things:
  - two-flop synchronization into the `clk` domain;
  - counter-based debounce;
  - one-cycle press and release pulse generation.
- Placed directly upstream of the wrapper in the top level. The wrapper consumes `btn_level`; `btn_press` is available for edge-triggered MMIO/interrupt use.

Parameters:
- NUM_BTNS, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a new level (5 ms at 100 MHz). Must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each channel counter (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn_raw  input  NUM_BTNS  unsynchronized, bouncing button inputs.
- btn_level  output  NUM_BTNS  debounced button level; drives wrapper `buttons`.
- btn_press  output  NUM_BTNS  one-cycle pulse when `btn_level[i]` rises.
- btn_release  output  NUM_BTNS  one-cycle pulse when `btn_level[i]` falls.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - all outputs go to 0 immediately;
  - synchronizer flops, counters and FSM states go to 0 / IDLE_LOW;
  - deassertion is sampled on `clk`.
- Channels are fully independent. No cross-channel priority or shared counter.
- Synchronizer: `sync1 <= btn_raw[i]`, `sync2 <= sync1`. Only `sync2` feeds the FSM.
- Per-channel FSM, 4 states:
  - IDLE_LOW: `level`=0. If `sync2`=1 → WAIT_HIGH, `cnt`<=1.
  - WAIT_HIGH:
    - If `sync2`=0 → IDLE_LOW, `cnt`<=0 (bounce rejected).
    - Else if `cnt`==DEBOUNCE_CYCLES-1 → IDLE_HIGH, `level`<=1, `press`<=1, `cnt`<=0.
    - Else `cnt`<=`cnt`+1.
  - IDLE_HIGH: `level`=1. If `sync2`=0 → WAIT_LOW, `cnt`<=1.
  - WAIT_LOW: mirror of WAIT_HIGH.
    - `sync2`=1 → IDLE_HIGH, `cnt`<=0.
    - Terminal count → IDLE_LOW, `level`<=0, `release`<=1.
- Acceptance rule: a new level is accepted only after DEBOUNCE_CYCLES consecutive rising edges observe `sync2` at the new value.
- Latency:
  - Define edge 0 as the first edge at which `btn_raw[i]` is captured at its new value.
  - `btn_level[i]` changes at edge DEBOUNCE_CYCLES+1.
  - `btn_press` / `btn_release` are registered and high for exactly the cycle following that edge, coincident with the first cycle of the new level.
- Pulses:
  - never high for more than one cycle;
  - `press` and `release` are never high together on the same channel;
  - at most one pulse per accepted transition.
- Counter never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.
- Glitch handling:
  - a reversal during WAIT_* restarts qualification from zero on the next excursion;
  - a pulse shorter than DEBOUNCE_CYCLES samples never changes `btn_level`.
- Reset mid-WAIT: the qualification in progress is discarded. If the button is still held after reset release, a full new qualification is required (latency as above from the first post-reset sampled edge).
- Button held through reset release produces a `btn_press` pulse; this is intended behaviour.

Test Plan (DEBOUNCE_CYCLES=4 for all scenarios):
- Clean press: `btn_raw[0]` 0→1, held; edge 0 = first capture.
  - Required: `btn_level[0]`=1 from edge 5.
  - Required: `btn_press[0]`=1 for exactly one cycle after edge 5.
  - Required: other channels stay 0.
- Glitch: `btn_raw[1]` high for 3 cycles then low.
  - Required: `btn_level[1]` stays 0; no press or release pulse.
- Bounce: `btn_raw[2]` toggles every 2 cycles for 12 cycles, then holds 1.
  - Required: single `btn_press[2]` pulse.
  - Required: `btn_level[2]` rises at edge 5 counted from the final 0→1 capture.
- Release: after scenario 1, `btn_raw[0]` 1→0.
  - Required: `btn_level[0]` falls at edge 5; one `btn_release[0]` pulse; no `btn_press`.
- Simultaneous: `btn_raw[3]` and `btn_raw[4]` rise on the same cycle; `btn_raw[4]` glitches low for 1 cycle at edge 2.
  - Required: channel 3 accepts at edge 5.
  - Required: channel 4 accepts at edge 5 counted from its recapture.
  - Required: the channels do not interact.
- Async reset mid-WAIT: `btn_raw[0]` held high, `rst`=0 asynchronously at edge 3.
  - Required: all outputs 0 immediately.
  - Required: after `rst`=1, `btn_level[0]` rises at edge 5 from the first post-reset capture, with one press pulse.
